// File: rtl/decade_up_counter.sv
`default_nettype none
// ============================================================================
//  Module      : decade_up_counter
//  Description : Four-digit BCD up counter (0000..9999) with an optional
//                2-flop input synchronizer, rising-edge tick detection,
//                saturating BCD parallel load and a one-cycle wrap pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module decade_up_counter #(
    parameter int SYNC_IN = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        in_pulse,
    input  logic        load,
    input  logic [15:0] load_value,
    output logic [15:0] cur_value,
    output logic        out_pulse
);

    localparam int         c_NUM_DIGITS = 4;
    localparam logic [3:0] c_MAX_DIGIT  = 4'd9;

    // ------------------------------------------------------------------------
    // Capture path: w_s2 is the clock-domain view of in_pulse, r_s3 is the
    // same signal one cycle older. A tick is the cycle where w_s2 has just
    // risen, so a level held high yields exactly one tick.
    // ------------------------------------------------------------------------
    logic w_s2;
    logic r_s3;
    logic w_tick;
    logic w_count_en;

    generate
        if (SYNC_IN != 0) begin : g_sync
            logic r_s1;
            logic r_s2;

            // Two-flop synchronizer for an asynchronous in_pulse
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_s1 <= 1'b0;
                    r_s2 <= 1'b0;
                end else begin
                    r_s1 <= in_pulse;
                    r_s2 <= r_s1;
                end
            end

            assign w_s2 = r_s2;
        end else begin : g_no_sync
            // Input is already synchronous: tick is seen on the same edge
            assign w_s2 = in_pulse;
        end
    endgenerate

    // Edge-detect history register; runs independently of enable and load
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s3 <= 1'b0;
        end else begin
            r_s3 <= w_s2;
        end
    end

    assign w_tick     = w_s2 & ~r_s3;
    // A disabled tick is simply lost; nothing remembers it for later
    assign w_count_en = w_tick & enable;

    // ------------------------------------------------------------------------
    // Per-digit datapath: incremented value with a combinational carry chain
    // and the saturated (BCD-clean) version of load_value.
    // w_carry[d] is the carry into digit d; w_carry[0] is the increment itself,
    // w_carry[c_NUM_DIGITS] is set only when the count is 9999 (full wrap).
    // ------------------------------------------------------------------------
    logic [15:0]             r_value;
    logic                    r_out_pulse;
    logic [15:0]             w_inc_value;
    logic [15:0]             w_load_sat;
    logic [c_NUM_DIGITS:0]   w_carry;
    logic                    w_wrap;

    assign w_carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < c_NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] w_cur_digit;
            logic [3:0] w_load_digit;
            logic [3:0] w_inc_digit;

            assign w_cur_digit  = r_value[4*gi +: 4];
            assign w_load_digit = load_value[4*gi +: 4];

            // Out-of-range load digits are clamped so the count stays BCD
            assign w_load_sat[4*gi +: 4] = (w_load_digit > c_MAX_DIGIT) ? c_MAX_DIGIT
                                                                        : w_load_digit;

            // Carry out of this digit when it receives a carry and is at 9
            assign w_carry[gi+1] = w_carry[gi] & (w_cur_digit >= c_MAX_DIGIT);

            // Next digit value for an increment: roll 9 to 0, else add one
            always_comb begin
                w_inc_digit = w_cur_digit;
                if (w_carry[gi]) begin
                    if (w_cur_digit >= c_MAX_DIGIT) begin
                        w_inc_digit = 4'd0;
                    end else begin
                        w_inc_digit = w_cur_digit + 4'd1;
                    end
                end
            end

            assign w_inc_value[4*gi +: 4] = w_inc_digit;
        end
    endgenerate

    assign w_wrap = w_carry[c_NUM_DIGITS];

    // Count register: reset beats load, load beats a counted tick; the whole
    // four-digit result is written in one edge so no ripple is ever visible
    always_ff @(posedge clock) begin
        if (reset) begin
            r_value     <= 16'h0000;
            r_out_pulse <= 1'b0;
        end else begin
            r_out_pulse <= 1'b0;
            if (load) begin
                r_value <= w_load_sat;
            end else if (w_count_en) begin
                r_value     <= w_inc_value;
                r_out_pulse <= w_wrap;
            end
        end
    end

    assign cur_value = r_value;
    assign out_pulse = r_out_pulse;

endmodule
`default_nettype wire

// File: tb/tb_decade_up_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decade_up_counter
//  Description : Scoreboard bench for decade_up_counter, driving a
//                synchronized (SYNC_IN=1) and a raw (SYNC_IN=0) instance
//                from the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decade_up_counter;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        in_pulse;
    logic        load;
    logic [15:0] load_value;
    logic [15:0] cur_s;
    logic        pls_s;
    logic [15:0] cur_r;
    logic        pls_r;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    decade_up_counter #(.SYNC_IN(1)) dut_sync (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .in_pulse   (in_pulse),
        .load       (load),
        .load_value (load_value),
        .cur_value  (cur_s),
        .out_pulse  (pls_s)
    );

    decade_up_counter #(.SYNC_IN(0)) dut_raw (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .in_pulse   (in_pulse),
        .load       (load),
        .load_value (load_value),
        .cur_value  (cur_r),
        .out_pulse  (pls_r)
    );

    typedef struct {
        logic [15:0] cur_s;
        logic        pls_s;
        logic [15:0] cur_r;
        logic        pls_r;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: integer count 0..9999, plus the last four in_pulse
    // samples seen at clock edges (index 0 = most recent). Reset empties the
    // capture pipeline. Instance 0 sees a rise two edges late, instance 1 at once.
    int m_val[2];
    bit m_pls[2];
    bit m_hist[2][4];
    bit in_state = 1'b0;

    function automatic int sat_load(input logic [15:0] lv);
        int v;
        int scale;
        int dig;
        v     = 0;
        scale = 1;
        for (int d = 0; d < 4; d++) begin
            dig = int'((lv >> (4*d)) & 16'h000F);
            if (dig > 9) dig = 9;
            v     += dig * scale;
            scale *= 10;
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_step(input bit rst, input bit en, input bit inp,
                              input bit ld, input logic [15:0] lv);
        for (int i = 0; i < 2; i++) begin
            bit tick;
            if (rst) begin
                m_val[i] = 0;
                m_pls[i] = 1'b0;
                for (int j = 0; j < 4; j++) m_hist[i][j] = 1'b0;
            end else begin
                if (i == 0) tick = m_hist[i][1] && !m_hist[i][2];
                else        tick = inp && !m_hist[i][0];
                m_pls[i] = 1'b0;
                if (ld) begin
                    m_val[i] = sat_load(lv);
                end else if (tick && en) begin
                    m_val[i] = (m_val[i] + 1) % 10000;
                    m_pls[i] = (m_val[i] == 0);
                end
                for (int j = 3; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
                m_hist[i][0] = inp;
            end
        end
    endtask

    // Drive one cycle of stimulus and queue the response expected after the edge
    task automatic cycle(input bit rst, input bit en, input bit inp,
                         input bit ld, input logic [15:0] lv);
        exp_t e;
        @(negedge clock);
        reset      = rst;
        enable     = en;
        in_pulse   = inp;
        load       = ld;
        load_value = lv;
        model_step(rst, en, inp, ld, lv);
        e.cur_s = to_bcd(m_val[0]);
        e.pls_s = m_pls[0];
        e.cur_r = to_bcd(m_val[1]);
        e.pls_r = m_pls[1];
        exp_q.push_back(e);
    endtask

    task automatic pulse(input int hi, input int lo, input bit en);
        repeat (hi) cycle(1'b0, en, 1'b1, 1'b0, 16'h0000);
        repeat (lo) cycle(1'b0, en, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    endtask

    // Direct checks of the synchronized instance against hand-derived values
    task automatic check_cur(input string name, input logic [15:0] exp);
        n_tests++;
        if (cur_s !== exp) begin
            n_fail++;
            $display("FAIL %s: cur_value=%h required=%h", name, cur_s, exp);
        end
    endtask

    task automatic check_pls(input string name, input logic exp);
        n_tests++;
        if (pls_s !== exp) begin
            n_fail++;
            $display("FAIL %s: out_pulse=%b required=%b", name, pls_s, exp);
        end
    endtask

    // Monitor: one expected response per clock edge once stimulus has started
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (cur_s !== e.cur_s || pls_s !== e.pls_s) begin
                    n_fail++;
                    $display("FAIL sync_inst @%0t: cur_value=%h out_pulse=%b required %h %b",
                             $time, cur_s, pls_s, e.cur_s, e.pls_s);
                end
                n_tests++;
                if (cur_r !== e.cur_r || pls_r !== e.pls_r) begin
                    n_fail++;
                    $display("FAIL raw_inst @%0t: cur_value=%h out_pulse=%b required %h %b",
                             $time, cur_r, pls_r, e.cur_r, e.pls_r);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        in_pulse   = 1'b0;
        load       = 1'b0;
        load_value = 16'h0000;

        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        check_cur("reset_value", 16'h0000);
        check_pls("reset_pulse", 1'b0);

        // Twelve clean pulses
        repeat (12) pulse(2, 2, 1'b1);
        idle(2);
        check_cur("twelve_ticks", 16'h0012);

        // Load near the top and wrap
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h9998);
        idle(2);
        check_cur("load_9998", 16'h9998);
        pulse(2, 2, 1'b1);
        idle(1);
        check_cur("tick_to_9999", 16'h9999);
        pulse(2, 2, 1'b1);
        idle(1);
        check_cur("wrap_to_0000", 16'h0000);
        pulse(2, 2, 1'b1);
        idle(1);
        check_cur("after_wrap", 16'h0001);

        // Load with a tick landing on the same edge (synced tick is 2 edges late)
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 16'h0199);
        idle(3);
        check_cur("load_drops_tick", 16'h0199);
        pulse(2, 2, 1'b1);
        idle(1);
        check_cur("carry_0199", 16'h0200);

        // Saturating load
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'hF3A7);
        idle(2);
        check_cur("load_saturate", 16'h9397);

        // Disabled ticks are dropped, long high level counts once
        repeat (5) pulse(2, 2, 1'b0);
        idle(1);
        check_cur("disabled_ticks", 16'h9397);
        pulse(2, 2, 1'b1);
        idle(1);
        check_cur("enabled_after_drop", 16'h9398);
        repeat (20) cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        idle(3);
        check_cur("held_high", 16'h9399);

        // Reset on the cycle out_pulse is high
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h9999);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        check_pls("wrap_pulse_high", 1'b1);
        check_cur("wrap_value", 16'h0000);
        idle(1);
        check_cur("reset_on_pulse_val", 16'h0000);
        check_pls("reset_on_pulse_pls", 1'b0);

        // Randomized traffic, biased toward loads near the wrap point
        in_state = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            bit          r;
            bit          l;
            bit          en;
            logic [15:0] v;
            r  = ($urandom_range(0, 99) < 1);
            l  = ($urandom_range(0, 99) < 2);
            en = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 99) < 40) in_state = ~in_state;
            if ($urandom_range(0, 1) == 0) v = 16'($urandom);
            else                           v = 16'h9990 + 16'($urandom_range(0, 9));
            cycle(r, en, in_state, l, v);
        end

        idle(3);
        repeat (2) @(posedge clock);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses left unchecked, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
